// File: rtl/sqrt_operand_sequencer.sv
// ----------------------------------------------------------------------------
// sqrt_operand_sequencer
//
// Purpose:
//   Buffers 8-bit operands in a small FIFO and feeds them one at a time to a
//   multi-cycle integer square-root core. The core has no done flag. After
//   each start pulse the sequencer waits a fixed number of cycles, captures
//   the root and presents it downstream together with the operand that
//   produced it. The result is held until the consumer accepts it. Only one
//   operand is in the core at any time, so results leave in push order.
//
// Parameters:
//   DEPTH        operand FIFO depth. Must be a power of two, 2..16.
//   WAIT_CYCLES  cycles from the issue edge to the result capture edge.
//                Must be at least 34, which is the core's worst-case latency.
//
// Ports:
//   i_clk          single clock; all state changes on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_in_valid     upstream operand valid
//   o_in_ready     FIFO not full (an operand is accepted on valid && ready)
//   i_in_data      operand
//   o_core_s       one-cycle start pulse to the sqrt core
//   o_core_x       operand to the sqrt core
//   i_core_sqrt    root returned by the sqrt core
//   o_out_valid    result available (high only while holding a result)
//   i_out_ready    downstream accepts the result
//   o_out_data     captured root
//   o_out_operand  operand that produced o_out_data
//   o_check_err    (only with SQRT_SEQ_CHECK_EN) root failed the range check
//
// Optional feature:
//   Define SQRT_SEQ_CHECK_EN to add o_check_err. At the capture edge it
//   registers whether r*r > X or (r+1)*(r+1) <= X, computed in 16 bits. The
//   flag is held through HOLD and cleared when HOLD is left. With the macro
//   undefined, the port and its arithmetic are absent.
// ----------------------------------------------------------------------------
module sqrt_operand_sequencer #(
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 40
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [7:0] i_in_data,
  output logic       o_core_s,
  output logic [7:0] o_core_x,
  input  logic [7:0] i_core_sqrt,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_data,
  output logic [7:0] o_out_operand
`ifdef SQRT_SEQ_CHECK_EN
  ,
  output logic       o_check_err
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WCNT_W = $clog2(WAIT_CYCLES);

  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_LOAD  = WCNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;

  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [WCNT_W-1:0] r_wait_cnt;
  logic [7:0]        r_operand;
  logic [7:0]        r_out_data;

  logic              w_push;
  logic              w_pop;
  logic              w_capture;
  logic [7:0]        w_head;

  // --------------------------------------------------------------------------
  // Operand FIFO
  // --------------------------------------------------------------------------
  // A full FIFO refuses new operands. No bypass path exists, so even an
  // operand pushed in the same cycle as a pop waits for a free slot.
  assign o_in_ready = (r_count != FULL_COUNT);
  assign w_push     = i_in_valid && o_in_ready;
  assign w_head     = r_mem[r_rd_ptr];

  // The storage has no reset. Reset only clears the pointers and the count,
  // so stale entries are never read back.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  // DEPTH is a power of two, so the natural pointer overflow wraps modulo
  // DEPTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // During ISSUE, o_core_x comes straight from the FIFO head. That lets the
  // start pulse and the operand reach the core in the same cycle. In every
  // other state o_core_x shows the latched operand, so the core input stays
  // steady while the core computes.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    o_core_s     = 1'b0;
    o_core_x     = r_operand;
    o_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_core_s     = 1'b1;
        o_core_x     = w_head;
        w_pop        = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Wait counter, operand latch and result capture
  // --------------------------------------------------------------------------
  // The counter loads WAIT_CYCLES-1 at the issue edge and then counts down
  // to zero. The capture edge therefore lands exactly WAIT_CYCLES edges
  // after the core saw the start pulse.
  assign w_capture = (r_state == ST_WAIT) && (r_wait_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait_cnt <= '0;
      r_operand  <= '0;
      r_out_data <= '0;
    end else begin
      case (r_state)
        ST_ISSUE: begin
          r_wait_cnt <= WAIT_LOAD;
          r_operand  <= w_head;
        end
        ST_WAIT: begin
          if (w_capture) begin
            r_out_data <= i_core_sqrt;
          end else begin
            r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
          end
        end
        default: begin
          r_wait_cnt <= r_wait_cnt;
        end
      endcase
    end
  end

  assign o_out_data    = r_out_data;
  assign o_out_operand = r_operand;

`ifdef SQRT_SEQ_CHECK_EN
  // --------------------------------------------------------------------------
  // Root range check
  // --------------------------------------------------------------------------
  // The check uses the root being captured at this edge (i_core_sqrt), so the
  // flag is valid in the first HOLD cycle. All arithmetic is 16 bits. For
  // r = 255, (r+1)^2 wraps to 0 and the check reports an error. That is
  // still correct, because 255 is never a valid root of an 8-bit operand.
  logic [15:0] w_root16;
  logic [15:0] w_root16_inc;
  logic [15:0] w_sq;
  logic [15:0] w_sq_inc;
  logic [15:0] w_operand16;
  logic        w_err;
  logic        r_check_err;

  assign w_root16     = {8'h00, i_core_sqrt};
  assign w_root16_inc = w_root16 + 16'd1;
  assign w_operand16  = {8'h00, r_operand};
  assign w_sq         = w_root16 * w_root16;
  assign w_sq_inc     = w_root16_inc * w_root16_inc;
  assign w_err        = (w_sq > w_operand16) || (w_sq_inc <= w_operand16);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_check_err <= 1'b0;
    end else if (w_capture) begin
      r_check_err <= w_err;
    end else if ((r_state == ST_HOLD) && i_out_ready) begin
      r_check_err <= 1'b0;
    end
  end

  assign o_check_err = r_check_err;
`endif

endmodule

// File: tb/tb_sqrt_operand_sequencer.sv
module tb_sqrt_operand_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 40;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'd0;
  logic       out_ready = 1'b0;
  logic [7:0] core_sqrt = 8'd0;

  logic       in_ready;
  logic       core_s;
  logic [7:0] core_x;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_operand;
`ifdef SQRT_SEQ_CHECK_EN
  logic       check_err;
`endif

  always #5 clk = ~clk;

  sqrt_operand_sequencer #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_data     (in_data),
    .o_core_s      (core_s),
    .o_core_x      (core_x),
    .i_core_sqrt   (core_sqrt),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_data    (out_data),
    .o_out_operand (out_operand)
`ifdef SQRT_SEQ_CHECK_EN
    ,
    .o_check_err   (check_err)
`endif
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behaviour of the core: floor square root. This core has a deliberate
  // defect: it returns 1 for X=0.
  function automatic int coref(input int x);
    int r;
    if (x == 0) return 1;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic bit errf(input int r, input int x);
    return (r * r > x) || ((r + 1) * (r + 1) <= x);
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // --------------------------------------------------------------------------
  // Core model
  // --------------------------------------------------------------------------
  // The root appears W-1 edges after the start edge, so only a capture
  // exactly W edges after the start edge sees it. Until then the core
  // drives a junk value.
  int         core_cnt = 0;
  logic [7:0] core_res = 8'd0;

  always @(posedge clk) begin
    if (core_s) begin
      core_cnt  <= W - 1;
      core_res  <= 8'(coref(int'(core_x)));
      core_sqrt <= 8'hA5;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_sqrt <= core_res;
    end
  end

  // --------------------------------------------------------------------------
  // Reference model and observation
  // --------------------------------------------------------------------------
  // The model tracks each job by the cycle number of its issue cycle. The
  // issue cycle has offset 0 and is the start-pulse cycle. Offsets 1..W are
  // the wait. From offset W+1 on, the result is held until it is accepted.
  logic [7:0] m_q[$];
  bit         m_job      = 1'b0;
  int         m_start    = 0;
  logic [7:0] m_x        = 8'd0;
  logic [7:0] m_last_op  = 8'd0;
  logic [7:0] m_last_res = 8'd0;
  bit         m_err      = 1'b0;
  int         cyc        = 0;

  int res_op[$];
  int res_data[$];
  int res_err[$];
  int s_cyc[$];
  int vrise_cyc[$];
  int push_cyc[$];
  int dut_acc    = 0;
  bit prev_valid = 1'b0;

  always @(negedge clk) begin
    int         rel;
    bit         exp_s;
    bit         exp_valid;
    bit         exp_ready;
    bit         do_push;
    bit         do_pop;
    logic [7:0] exp_x;
    if (!rst_n) begin
      m_q.delete();
      m_job      = 1'b0;
      m_last_op  = 8'd0;
      m_last_res = 8'd0;
      m_err      = 1'b0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_core_s", int'(core_s), 0);
      chk("rst_core_x", int'(core_x), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_operand", int'(out_operand), 0);
    end else begin
      rel       = m_job ? (cyc - m_start) : -1;
      exp_s     = m_job && (rel == 0);
      exp_x     = exp_s ? m_q[0] : m_last_op;
      exp_valid = m_job && (rel >= W + 1);
      exp_ready = (m_q.size() < DEPTH);
      chk("in_ready", int'(in_ready), int'(exp_ready));
      chk("core_s", int'(core_s), int'(exp_s));
      chk("core_x", int'(core_x), int'(exp_x));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("out_data", int'(out_data), int'(m_last_res));
      chk("out_operand", int'(out_operand), int'(m_last_op));
`ifdef SQRT_SEQ_CHECK_EN
      chk("check_err", int'(check_err), int'(m_err));
`endif

      // observation of the DUT handshakes
      if (in_valid && in_ready) begin
        dut_acc++;
        push_cyc.push_back(cyc);
      end
      if (core_s) s_cyc.push_back(cyc);
      if (out_valid && !prev_valid) vrise_cyc.push_back(cyc);
      if (out_valid && out_ready) begin
        res_op.push_back(int'(out_operand));
        res_data.push_back(int'(out_data));
`ifdef SQRT_SEQ_CHECK_EN
        res_err.push_back(int'(check_err));
`endif
        $display("result: operand=%0d root=%0d cycle=%0d", out_operand, out_data, cyc);
      end

      // advance the model to the next cycle
      do_push = in_valid && (m_q.size() < DEPTH);
      do_pop  = 1'b0;
      if (m_job) begin
        if (rel == 0) begin
          do_pop    = 1'b1;
          m_last_op = m_x;
        end
        if (rel == W) begin
          m_last_res = 8'(coref(int'(m_x)));
          m_err      = errf(int'(m_last_res), int'(m_x));
        end
        if ((rel >= W + 1) && out_ready) begin
          m_job = 1'b0;
          m_err = 1'b0;
        end
      end else if (m_q.size() > 0) begin
        m_job   = 1'b1;
        m_start = cyc + 1;
        m_x     = m_q[0];
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(in_data);
    end
    prev_valid = out_valid;
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    res_op.delete();
    res_data.delete();
    res_err.delete();
    s_cyc.delete();
    vrise_cyc.delete();
    push_cyc.delete();
    dut_acc = 0;
  endtask

  task automatic wait_results(input int n, input int budget, input string name);
    int c;
    c = 0;
    while ((res_data.size() < n) && (c < budget)) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk(name, res_data.size(), n);
  endtask

  // --------------------------------------------------------------------------
  // Directed scenarios
  // --------------------------------------------------------------------------
  initial begin
    int exp_roots[5];
    int exp_ops[5];

    #1 rst_n = 1'b0;
    idle(3);
    chk("lit_reset_in_ready", int'(in_ready), 1);
    chk("lit_reset_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;

    // single operand 16, latency from the first non-empty cycle
    out_ready = 1'b1;
    clear_obs();
    push(8'd16);
    wait_results(1, 2 * W + 20, "s1_done");
    idle(5);
    chk("s1_root", qget(res_data, 0), 4);
    chk("s1_operand", qget(res_op, 0), 16);
    chk("s1_latency", qget(vrise_cyc, 0) - (qget(push_cyc, 0) + 1), W + 2);
    chk("s1_pulses", s_cyc.size(), 1);
`ifdef SQRT_SEQ_CHECK_EN
    chk("s1_check_err", qget(res_err, 0), 0);
`endif

    // back-to-back 255, 100, 2
    clear_obs();
    push(8'd255);
    push(8'd100);
    push(8'd2);
    wait_results(3, 3 * (W + 6) + 20, "s2_done");
    idle(5);
    chk("s2_root0", qget(res_data, 0), 15);
    chk("s2_root1", qget(res_data, 1), 10);
    chk("s2_root2", qget(res_data, 2), 1);
    chk("s2_op0", qget(res_op, 0), 255);
    chk("s2_pulses", s_cyc.size(), 3);
    chk("s2_gap01", int'((qget(s_cyc, 1) - qget(s_cyc, 0)) >= W + 2), 1);
    chk("s2_gap12", int'((qget(s_cyc, 2) - qget(s_cyc, 1)) >= W + 2), 1);

    // back-pressure: 6 pushes, 1 in flight + 4 queued, 1 dropped
    clear_obs();
    out_ready = 1'b0;
    push(8'd9);
    push(8'd25);
    push(8'd49);
    push(8'd64);
    push(8'd121);
    push(8'd144);
    idle(W + 10);
    chk("s3_in_ready_full", int'(in_ready), 0);
    chk("s3_accepted", dut_acc, 5);
    chk("s3_no_early_result", res_data.size(), 0);
    out_ready = 1'b1;
    wait_results(5, 5 * (W + 6) + 20, "s3_done");
    idle(W + 10);
    chk("s3_drained", res_data.size(), 5);
    exp_roots = '{3, 5, 7, 8, 11};
    exp_ops   = '{9, 25, 49, 64, 121};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s3_root%0d", i), qget(res_data, i), exp_roots[i]);
      chk($sformatf("s3_op%0d", i), qget(res_op, i), exp_ops[i]);
    end

    // X=0 against the faulty core, which returns 1
    clear_obs();
    push(8'd0);
    wait_results(1, 2 * W + 20, "s4_done");
    idle(5);
    chk("s4_root", qget(res_data, 0), 1);
    chk("s4_operand", qget(res_op, 0), 0);
`ifdef SQRT_SEQ_CHECK_EN
    chk("s4_check_err", qget(res_err, 0), 1);
`endif

    // reset for 2 cycles during the wait of X=200 with two operands queued
    clear_obs();
    push(8'd200);
    push(8'd50);
    push(8'd60);
    idle(10);
    rst_n = 1'b0;
    idle(2);
    chk("s5_rst_out_valid", int'(out_valid), 0);
    chk("s5_rst_core_s", int'(core_s), 0);
    chk("s5_rst_in_ready", int'(in_ready), 1);
    chk("s5_rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    idle(3 * (W + 6));
    chk("s5_discarded", res_data.size(), 0);
    chk("s5_pulses", s_cyc.size(), 1);
    clear_obs();
    push(8'd81);
    wait_results(1, 2 * W + 20, "s5_done");
    idle(5);
    chk("s5_root", qget(res_data, 0), 9);
    chk("s5_operand", qget(res_op, 0), 81);

    // push during ISSUE with two queued: order must be preserved
    clear_obs();
    push(8'd36);
    push(8'd49);
    push(8'd4);
    wait_results(3, 3 * (W + 6) + 20, "s6_done");
    idle(5);
    chk("s6_root0", qget(res_data, 0), 6);
    chk("s6_root1", qget(res_data, 1), 7);
    chk("s6_root2", qget(res_data, 2), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sqrt_operand_sequencer.md
SQRT_OPERAND_SEQUENCER -- requirements
Module: sqrt_operand_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO depth; power of two; range 2..16.
REQ-002 Parameter WAIT_CYCLES, default 40, clock cycles from the issue edge to the result capture; minimum 34, which is the worst-case core latency at X=255.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream operand valid.
REQ-006 in_ready  output  1  FIFO can accept an operand.
REQ-007 in_data  input  8  operand.
REQ-008 core_S  output  1  start pulse to the sqrt core.
REQ-009 core_X  output  8  operand to the sqrt core.
REQ-010 core_sqrt  input  8  result from the sqrt core.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_data  output  8  captured root.
REQ-014 out_operand  output  8  operand that produced out_data.

Function
REQ-015 A push SHALL occur on in_valid && in_ready; in_ready SHALL equal "FIFO not full"; there is no bypass when full.
REQ-016 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and HOLD.
REQ-018 IDLE SHALL move to ISSUE when the FIFO is non-empty, and otherwise stay in IDLE.
REQ-019 In ISSUE, for exactly one cycle: core_S=1, core_X=FIFO head, the head SHALL be popped and latched into out_operand, the wait counter SHALL load WAIT_CYCLES-1, and the next state SHALL be WAIT.
REQ-020 In WAIT, core_S SHALL be 0 and core_X SHALL hold the latched operand; the counter SHALL decrement every cycle; at count 0, out_data SHALL capture core_sqrt and the next state SHALL be HOLD.
REQ-021 In HOLD, out_valid SHALL be 1; out_data and out_operand SHALL be stable; on out_ready the FSM SHALL go to IDLE.
REQ-022 out_valid SHALL be 0 in all states other than HOLD.
REQ-023 Operand-to-result latency SHALL be 1 cycle (IDLE to ISSUE) plus 1 (ISSUE) plus WAIT_CYCLES, measured from the first cycle the FIFO is non-empty.
REQ-024 At most one operand SHALL be in flight in the core; pushes SHALL continue during ISSUE, WAIT and HOLD.
REQ-025 The result order SHALL equal the operand push order.
REQ-026 out_ready asserted outside HOLD SHALL be ignored.

Reset
REQ-027 On Reset=0, regardless of Clk, the block SHALL immediately enter IDLE and clear the FIFO pointers, count and wait counter.
REQ-028 On Reset=0, core_S, core_X, out_valid, out_data and out_operand SHALL go to 0; in_ready SHALL go to 1.
REQ-029 Reset asserted mid-WAIT or mid-HOLD SHALL discard the in-flight operand, its result and all queued operands without emitting a result.
REQ-030 The first push SHALL be accepted on the first rising edge after Reset returns to 1.

Configuration
REQ-031 When macro SQRT_SEQ_CHECK_EN is defined, the block SHALL provide output port check_err (1 bit).
REQ-032 With SQRT_SEQ_CHECK_EN defined, check_err SHALL be registered at the HOLD capture edge and held through HOLD, cleared on leaving HOLD and on reset.
REQ-033 With SQRT_SEQ_CHECK_EN defined, check_err SHALL be 1 when r*r > X or (r+1)*(r+1) <= X, where r=out_data and X=out_operand, computed at 16-bit width.
REQ-034 When SQRT_SEQ_CHECK_EN is undefined, check_err and its arithmetic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Scenario: push X=16, out_ready=1 -> core_S pulses once; out_valid rises WAIT_CYCLES+2 cycles after the push is visible; out_data=4, out_operand=16; check_err=0.
REQ-036 Scenario: push 255, 100, 2 back-to-back with out_ready=1 -> results 15, 10, 1 in that order; exactly 3 core_S pulses, each separated by at least WAIT_CYCLES+2 cycles.
REQ-037 Scenario: out_ready=0, push 6 operands with DEPTH=4 -> 1 in flight, then FIFO full and in_ready=0; excess pushes are dropped and not counted; raising out_ready drains exactly 5 results.
REQ-038 Scenario: push X=0 with SQRT_SEQ_CHECK_EN defined -> core returns 1, out_data=1, check_err=1.
REQ-039 Scenario: Reset=0 for 2 cycles during WAIT of X=200 -> out_valid, core_S and FIFO count all 0; after release a push of 81 yields out_data=9.
REQ-040 Scenario: simultaneous push and pop in the ISSUE cycle with count=2 -> count remains 2; the next issued operand is the older queued entry.
